test_control_axil_regs: RTL and testbench

- AXI4-Lite responder (slave) register file for the test_control IP. It is the target end of the S00_AXI interface driven by the AXI4-Lite master BFM.
- Implements four 32-bit read/write control registers at word offsets 0x0/0x4/0x8/0xC, with byte strobes.
- Decodes out-of-range addresses to SLVERR.
- Exports register contents and per-register write pulses to fabric logic.

---
 rtl/test_control_axil_regs.sv | 140 ++++++++++++++
 tb/tb_test_control_axil_regs.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_control_axil_regs.sv
// AXI4-Lite responder for the test_control IP: four byte-strobed 32-bit control registers.
// Words beyond index 3 answer SLVERR. Register contents and per-register write pulses go to fabric.
module test_control_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   ctrl_regs,
  output logic [3:0]                        ctrl_wr_pulse
);

  localparam int          STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int          IDX_W    = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] NUM_REGS = IDX_W'(4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                          ready_en;
  logic                          aw_full;
  logic                          w_full;
  logic [IDX_W-1:0]              aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]             w_strb;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_mask;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
  logic [IDX_W-1:0]              ar_idx;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          commit;
  logic                          aw_in_range;
  logic                          unused_ok;

  // Readies stay low while in reset and rise on the first clock after release.
  assign s00_axi_awready = ready_en & ~aw_full;
  assign s00_axi_wready  = ready_en & ~w_full;
  assign s00_axi_arready = ready_en & (~s00_axi_rvalid | s00_axi_rready);

  assign aw_hs       = s00_axi_awvalid & s00_axi_awready;
  assign w_hs        = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs       = s00_axi_arvalid & s00_axi_arready;
  assign commit      = aw_full & w_full & (~s00_axi_bvalid | s00_axi_bready);
  assign aw_in_range = aw_idx < NUM_REGS;
  assign ar_idx      = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

  assign ctrl_regs = {regs[3], regs[2], regs[1], regs[0]};
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  for (genvar b = 0; b < STRB_W; b++) begin : g_mask
    assign wr_mask[8*b +: 8] = {8{w_strb[b]}};
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      ready_en <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      regs           <= '{default: '0};
      ctrl_wr_pulse  <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
    end else begin
      ctrl_wr_pulse <= '0;
      if (commit) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        if (aw_in_range) begin
          regs[aw_idx[1:0]]          <= (regs[aw_idx[1:0]] & ~wr_mask) | (w_data & wr_mask);
          ctrl_wr_pulse[aw_idx[1:0]] <= 1'b1;
        end
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read samples regs before any same-edge commit lands, so a colliding read sees the old value.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s00_axi_rvalid <= 1'b1;
      if (ar_idx < NUM_REGS) begin
        s00_axi_rdata <= regs[ar_idx[1:0]];
        s00_axi_rresp <= RESP_OKAY;
      end else begin
        s00_axi_rdata <= '0;
        s00_axi_rresp <= RESP_SLVERR;
      end
    end else if (s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_test_control_axil_regs.sv
// Directed bench for test_control_axil_regs: register access, strobes, SLVERR decode,
// channel backpressure, read/write collision and reset during a write.
module tb_test_control_axil_regs;

  logic         tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic         s00_axi_areset;
  logic [5:0]   s00_axi_awaddr;
  logic [2:0]   s00_axi_awprot;
  logic         s00_axi_awvalid;
  logic         s00_axi_awready;
  logic [31:0]  s00_axi_wdata;
  logic [3:0]   s00_axi_wstrb;
  logic         s00_axi_wvalid;
  logic         s00_axi_wready;
  logic [1:0]   s00_axi_bresp;
  logic         s00_axi_bvalid;
  logic         s00_axi_bready;
  logic [5:0]   s00_axi_araddr;
  logic [2:0]   s00_axi_arprot;
  logic         s00_axi_arvalid;
  logic         s00_axi_arready;
  logic [31:0]  s00_axi_rdata;
  logic [1:0]   s00_axi_rresp;
  logic         s00_axi_rvalid;
  logic         s00_axi_rready;
  logic [127:0] ctrl_regs;
  logic [3:0]   ctrl_wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  resp;
  logic [31:0] rd;
  logic [3:0]  pul;

  test_control_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6)
  ) dut (
    .s00_axi_aclk    (tb_ACLK),
    .s00_axi_areset  (s00_axi_areset),
    .s00_axi_awaddr  (s00_axi_awaddr),
    .s00_axi_awprot  (s00_axi_awprot),
    .s00_axi_awvalid (s00_axi_awvalid),
    .s00_axi_awready (s00_axi_awready),
    .s00_axi_wdata   (s00_axi_wdata),
    .s00_axi_wstrb   (s00_axi_wstrb),
    .s00_axi_wvalid  (s00_axi_wvalid),
    .s00_axi_wready  (s00_axi_wready),
    .s00_axi_bresp   (s00_axi_bresp),
    .s00_axi_bvalid  (s00_axi_bvalid),
    .s00_axi_bready  (s00_axi_bready),
    .s00_axi_araddr  (s00_axi_araddr),
    .s00_axi_arprot  (s00_axi_arprot),
    .s00_axi_arvalid (s00_axi_arvalid),
    .s00_axi_arready (s00_axi_arready),
    .s00_axi_rdata   (s00_axi_rdata),
    .s00_axi_rresp   (s00_axi_rresp),
    .s00_axi_rvalid  (s00_axi_rvalid),
    .s00_axi_rready  (s00_axi_rready),
    .ctrl_regs       (ctrl_regs),
    .ctrl_wr_pulse   (ctrl_wr_pulse)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
  endtask

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r, output logic [3:0] p);
    bit aw_done = 0;
    bit w_done  = 0;
    int cyc     = 0;
    s00_axi_awaddr  = a;
    s00_axi_wdata   = d;
    s00_axi_wstrb   = s;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid  = 1'b1;
    while (!(aw_done && w_done)) begin
      if (s00_axi_awvalid && s00_axi_awready) aw_done = 1;
      if (s00_axi_wvalid && s00_axi_wready)   w_done  = 1;
      tick();
      if (aw_done) s00_axi_awvalid = 1'b0;
      if (w_done)  s00_axi_wvalid  = 1'b0;
      cyc++;
      if (cyc > 20) begin
        check("aw_w_handshake_timeout", {aw_done, w_done}, 2'b11);
        s00_axi_awvalid = 1'b0;
        s00_axi_wvalid  = 1'b0;
        break;
      end
    end
    cyc = 0;
    while (!s00_axi_bvalid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bvalid", s00_axi_bvalid, 1'b1);
    r = s00_axi_bresp;
    p = ctrl_wr_pulse;
    tick();
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int cyc = 0;
    s00_axi_araddr  = a;
    s00_axi_arvalid = 1'b1;
    while (!s00_axi_arready && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    s00_axi_arvalid = 1'b0;
    check("rvalid", s00_axi_rvalid, 1'b1);
    d = s00_axi_rdata;
    r = s00_axi_rresp;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s00_axi_areset  = 1'b1;
    s00_axi_awaddr  = '0;
    s00_axi_awprot  = '0;
    s00_axi_awvalid = 1'b0;
    s00_axi_wdata   = '0;
    s00_axi_wstrb   = '0;
    s00_axi_wvalid  = 1'b0;
    s00_axi_bready  = 1'b1;
    s00_axi_araddr  = '0;
    s00_axi_arprot  = '0;
    s00_axi_arvalid = 1'b0;
    s00_axi_rready  = 1'b1;
    repeat (3) @(negedge tb_ACLK);

    // Reset state
    check("rst_readies", {s00_axi_awready, s00_axi_wready, s00_axi_arready}, 3'b000);
    check("rst_valids", {s00_axi_bvalid, s00_axi_rvalid}, 2'b00);
    check("rst_resp_rdata", {s00_axi_bresp, s00_axi_rresp, s00_axi_rdata}, 36'h0);
    check("rst_regs", ctrl_regs, 128'h0);
    check("rst_pulse", ctrl_wr_pulse, 4'b0000);
    s00_axi_areset = 1'b0;
    tick();
    check("post_rst_readies", {s00_axi_awready, s00_axi_wready, s00_axi_arready}, 3'b111);

    // Write then read all four registers
    axi_write(6'h00, 32'h0101FFFF, 4'hF, resp, pul);
    check("w0_bresp", resp, 2'b00);
    check("w0_pulse", pul, 4'b0001);
    axi_write(6'h04, 32'habcd0001, 4'hF, resp, pul);
    check("w1_bresp", resp, 2'b00);
    axi_write(6'h08, 32'hdead0011, 4'hF, resp, pul);
    check("w2_bresp", resp, 2'b00);
    axi_write(6'h0C, 32'hbeef0011, 4'hF, resp, pul);
    check("w3_bresp", resp, 2'b00);
    check("w3_pulse", pul, 4'b1000);
    axi_read(6'h00, rd, resp);
    check("r0", {resp, rd}, {2'b00, 32'h0101FFFF});
    axi_read(6'h04, rd, resp);
    check("r1", {resp, rd}, {2'b00, 32'habcd0001});
    axi_read(6'h08, rd, resp);
    check("r2", {resp, rd}, {2'b00, 32'hdead0011});
    axi_read(6'h0C, rd, resp);
    check("r3", {resp, rd}, {2'b00, 32'hbeef0011});
    check("regs_all", ctrl_regs, {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101FFFF});

    // W three cycles ahead of AW
    s00_axi_wdata  = 32'h12345678;
    s00_axi_wstrb  = 4'hF;
    s00_axi_wvalid = 1'b1;
    tick();
    s00_axi_wvalid = 1'b0;
    check("wfirst_wready_low", s00_axi_wready, 1'b0);
    tick();
    tick();
    check("wfirst_still_waiting", {s00_axi_wready, s00_axi_bvalid}, 2'b00);
    s00_axi_awaddr  = 6'h04;
    s00_axi_awvalid = 1'b1;
    tick();
    s00_axi_awvalid = 1'b0;
    check("wfirst_bvalid_1cyc", s00_axi_bvalid, 1'b0);
    tick();
    check("wfirst_b_2cyc", {s00_axi_bvalid, s00_axi_bresp, ctrl_wr_pulse}, {1'b1, 2'b00, 4'b0010});
    check("wfirst_reg1", ctrl_regs[63:32], 32'h12345678);
    tick();
    check("wfirst_pulse_gone", {s00_axi_bvalid, ctrl_wr_pulse}, 5'b0);

    // Strobed write into reg2 (bytes 0 and 2) and a zero-strobe write into reg3
    axi_write(6'h08, 32'hAAAAAAAA, 4'b0101, resp, pul);
    check("strb_bresp_pulse", {resp, pul}, {2'b00, 4'b0100});
    axi_read(6'h08, rd, resp);
    check("strb_read", {resp, rd}, {2'b00, 32'hdeaa00aa});
    axi_write(6'h0C, 32'h01234567, 4'b0000, resp, pul);
    check("zstrb_pulse", {resp, pul}, {2'b00, 4'b1000});
    check("zstrb_reg3", ctrl_regs[127:96], 32'hbeef0011);

    // Out-of-range access and ignored low address bits
    axi_write(6'h10, 32'hFFFFFFFF, 4'hF, resp, pul);
    check("oor_bresp_pulse", {resp, pul}, {2'b10, 4'b0000});
    check("oor_regs", ctrl_regs, {32'hbeef0011, 32'hdeaa00aa, 32'h12345678, 32'h0101FFFF});
    axi_read(6'h3C, rd, resp);
    check("oor_read", {resp, rd}, {2'b10, 32'h0});
    axi_read(6'h06, rd, resp);
    check("lowbits_read", {resp, rd}, {2'b00, 32'h12345678});

    // B backpressure with a second write queued behind it
    s00_axi_bready  = 1'b0;
    s00_axi_awaddr  = 6'h00;
    s00_axi_wdata   = 32'h11112222;
    s00_axi_wstrb   = 4'hF;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid  = 1'b1;
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_wvalid  = 1'b0;
    tick();
    check("bp_first_b", {s00_axi_bvalid, s00_axi_bresp}, 3'b1_00);
    s00_axi_awaddr  = 6'h14;
    s00_axi_wdata   = 32'h33334444;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid  = 1'b1;
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_wvalid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_hold", {s00_axi_bvalid, s00_axi_bresp, s00_axi_awready, s00_axi_wready}, 5'b1_00_00);
      tick();
    end
    s00_axi_bready = 1'b1;
    tick();
    check("bp_second_b", {s00_axi_bvalid, s00_axi_bresp, s00_axi_awready}, 4'b1_10_1);
    tick();
    check("bp_done", s00_axi_bvalid, 1'b0);
    check("bp_reg0", ctrl_regs[31:0], 32'h11112222);

    // R backpressure with a second read queued
    s00_axi_rready  = 1'b0;
    s00_axi_araddr  = 6'h04;
    s00_axi_arvalid = 1'b1;
    tick();
    s00_axi_araddr  = 6'h08;
    for (int i = 0; i < 3; i++) begin
      check("rbp_hold", {s00_axi_rvalid, s00_axi_arready, s00_axi_rdata}, {2'b10, 32'h12345678});
      tick();
    end
    s00_axi_rready = 1'b1;
    tick();
    s00_axi_arvalid = 1'b0;
    check("rbp_b2b", {s00_axi_rvalid, s00_axi_rresp, s00_axi_rdata}, {3'b1_00, 32'hdeaa00aa});
    tick();
    check("rbp_done", s00_axi_rvalid, 1'b0);

    // Read and commit to reg3 on the same edge
    s00_axi_awaddr  = 6'h0C;
    s00_axi_wdata   = 32'h55556666;
    s00_axi_wstrb   = 4'hF;
    s00_axi_awvalid = 1'b1;
    s00_axi_wvalid  = 1'b1;
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_wvalid  = 1'b0;
    s00_axi_araddr  = 6'h0C;
    s00_axi_arvalid = 1'b1;
    tick();
    s00_axi_arvalid = 1'b0;
    check("coll_old_value", {s00_axi_rvalid, s00_axi_bvalid, s00_axi_rdata}, {2'b11, 32'hbeef0011});
    tick();
    axi_read(6'h0C, rd, resp);
    check("coll_new_value", rd, 32'h55556666);

    // Reset between AW and W
    s00_axi_awaddr  = 6'h08;
    s00_axi_awvalid = 1'b1;
    tick();
    s00_axi_awvalid = 1'b0;
    s00_axi_areset  = 1'b1;
    #1;
    check("midrst_regs_async", ctrl_regs, 128'h0);
    tick();
    check("midrst_readies", {s00_axi_awready, s00_axi_wready, s00_axi_bvalid}, 3'b000);
    s00_axi_areset = 1'b0;
    tick();
    check("midrst_aw_empty", {s00_axi_awready, s00_axi_wready}, 2'b11);
    tick();
    tick();
    check("midrst_no_b", {s00_axi_bvalid, ctrl_wr_pulse}, 5'b0);
    axi_write(6'h08, 32'h9abcdef0, 4'hF, resp, pul);
    check("midrst_next_write", {resp, pul}, {2'b00, 4'b0100});
    check("midrst_regs", ctrl_regs, {32'h0, 32'h9abcdef0, 32'h0, 32'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
